sensor_frame_ctrl: RTL and testbench

Next-generation sensor front-end controller. It merges clock division, ST generation, EOC/EOS synchronisation and edge detection, and pixel counting into one FPGA_CLK-domain block. All sensor timing is runtime-enabled. Frames are delimited by EOS. Each completed frame yields a latched pixel count plus error flags. It sits between the sensor pins and the downstream ADC capture and LED/status logic, replacing the separate divider, ST, edge-detect and counter blocks.

---
 rtl/sensor_frame_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_sensor_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_ctrl.sv
// Sensor front-end controller: SENSOR_CLK divider, ST generator, EOC/EOS
// synchronisation and edge detection, and per-frame pixel counting with
// sticky error flags. Everything runs on FPGA_CLK; SENSOR_CLK is a plain
// register output, never used as a clock internally.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | disabled or just out of reset; no strobes
// S_SYNC | waiting for the first EOS edge; EOC edges are discarded
// S_ACQ  | counting EOC edges; each EOS edge closes a frame
module sensor_frame_ctrl #(
  parameter int DIV         = 8,
  parameter int ST_PERIOD   = 40000,
  parameter int ST_HIGH     = 6000,
  parameter int NPIX        = 1024,
  parameter int PIX_W       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST,
  input  logic             EN,
  input  logic             CLR_ERR,
  input  logic             EOC,
  input  logic             EOS,
  output logic             SENSOR_CLK,
  output logic             ST,
  output logic             PIX_VALID,
  output logic [PIX_W-1:0] PIX_INDEX,
  output logic             FRAME_DONE,
  output logic [PIX_W-1:0] FRAME_COUNT,
  output logic             ERR_COUNT,
  output logic             ERR_OVF
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ST_W  = $clog2(ST_PERIOD);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(ST_PERIOD - 1);
  localparam logic [ST_W-1:0]  ST_ON    = ST_W'(ST_PERIOD - ST_HIGH);
  localparam logic [PIX_W-1:0] NPIX_V   = PIX_W'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_ACQ  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic [ST_W-1:0]  r_st_cnt;
  logic             r_st;

  logic [SYNC_STAGES-1:0] r_eoc_sync;
  logic [SYNC_STAGES-1:0] r_eos_sync;
  logic                   r_eoc_dly;
  logic                   r_eos_dly;

  logic [PIX_W-1:0] r_pix_cnt;
  logic             r_pix_valid;
  logic [PIX_W-1:0] r_pix_index;
  logic             r_frame_done;
  logic [PIX_W-1:0] r_frame_count;
  logic             r_err_count;
  logic             r_err_ovf;

  logic             w_div_tc;
  logic             w_sclk_rise;
  logic [ST_W-1:0]  w_st_next;
  logic             w_eoc_edge;
  logic             w_eos_edge;
  logic             w_pix_fire;
  logic             w_frame_fire;
  logic             w_align;
  logic             w_cnt_sat;
  logic [PIX_W-1:0] w_cnt_inc;
  logic [PIX_W-1:0] w_cnt_after;
  logic             w_ovf_set;
  logic             w_cnt_err_set;

  assign w_div_tc    = (r_div_cnt == DIV_LAST);
  // The cycle on which the SENSOR_CLK register goes 0->1.
  assign w_sclk_rise = EN & w_div_tc & ~r_sclk;
  assign w_st_next   = (r_st_cnt == ST_LAST) ? '0 : r_st_cnt + ST_W'(1);

  assign w_eoc_edge  = r_eoc_sync[SYNC_STAGES-1] & ~r_eoc_dly;
  assign w_eos_edge  = r_eos_sync[SYNC_STAGES-1] & ~r_eos_dly;

  // An EOC landing with the EOS still belongs to the closing frame, so the
  // frame count is taken after this cycle's increment.
  assign w_cnt_sat     = (r_pix_cnt == '1);
  assign w_cnt_inc     = w_cnt_sat ? r_pix_cnt : r_pix_cnt + PIX_W'(1);
  assign w_cnt_after   = w_pix_fire ? w_cnt_inc : r_pix_cnt;
  assign w_ovf_set     = w_pix_fire & w_cnt_sat;
  assign w_cnt_err_set = w_frame_fire & (w_cnt_after != NPIX_V);

  // SENSOR_CLK divider: toggle at terminal count, forced low while disabled.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (!EN) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // ST period counter advances per SENSOR_CLK rise; ST follows the new count.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_st_cnt <= '0;
      r_st     <= 1'b0;
    end else if (!EN) begin
      r_st_cnt <= '0;
      r_st     <= 1'b0;
    end else if (w_sclk_rise) begin
      r_st_cnt <= w_st_next;
      r_st     <= (w_st_next >= ST_ON);
    end
  end

  // EOC/EOS synchronisers plus delay flops for rising-edge detection.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_eoc_sync <= '0;
      r_eos_sync <= '0;
      r_eoc_dly  <= 1'b0;
      r_eos_dly  <= 1'b0;
    end else begin
      r_eoc_sync <= {r_eoc_sync[SYNC_STAGES-2:0], EOC};
      r_eos_sync <= {r_eos_sync[SYNC_STAGES-2:0], EOS};
      r_eoc_dly  <= r_eoc_sync[SYNC_STAGES-1];
      r_eos_dly  <= r_eos_sync[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // FSM next state and per-cycle pixel/frame fire decisions.
  always_comb begin
    w_next_state = r_state;
    w_pix_fire   = 1'b0;
    w_frame_fire = 1'b0;
    w_align      = 1'b0;
    if (!EN) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_SYNC;
        S_SYNC: begin
          if (w_eos_edge) begin
            w_next_state = S_ACQ;
            w_align      = 1'b1;
          end
        end
        S_ACQ: begin
          w_pix_fire   = w_eoc_edge;
          w_frame_fire = w_eos_edge;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Pixel counter, strobes and the latched frame result.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_pix_cnt     <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_index   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (!EN || w_align || w_frame_fire) r_pix_cnt <= '0;
      else                                r_pix_cnt <= w_cnt_after;
      r_pix_valid  <= w_pix_fire;
      r_frame_done <= w_frame_fire;
      if (w_pix_fire)   r_pix_index   <= r_pix_cnt;
      if (w_frame_fire) r_frame_count <= w_cnt_after;
    end
  end

  // Sticky error flags; a set in the same cycle as CLR_ERR wins.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_err_count <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_cnt_err_set) r_err_count <= 1'b1;
      else if (CLR_ERR)  r_err_count <= 1'b0;
      if (w_ovf_set)     r_err_ovf   <= 1'b1;
      else if (CLR_ERR)  r_err_ovf   <= 1'b0;
    end
  end

  assign SENSOR_CLK  = r_sclk;
  assign ST          = r_st;
  assign PIX_VALID   = r_pix_valid;
  assign PIX_INDEX   = r_pix_index;
  assign FRAME_DONE  = r_frame_done;
  assign FRAME_COUNT = r_frame_count;
  assign ERR_COUNT   = r_err_count;
  assign ERR_OVF     = r_err_ovf;

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Bench for sensor_frame_ctrl: frame-level reference model feeding expected
// pixel/frame events into queues, a monitor that pops them on each strobe,
// and an arithmetic model of SENSOR_CLK/ST from the enabled cycle count.
module tb_sensor_frame_ctrl;
  localparam int DIV         = 2;
  localparam int ST_PERIOD   = 10;
  localparam int ST_HIGH     = 3;
  localparam int NPIX        = 4;
  localparam int PIX_W       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int PIX_MAX     = (1 << PIX_W) - 1;
  localparam int LAT         = SYNC_STAGES + 1;

  logic             FPGA_CLK = 1'b0;
  logic             FPGA_RST = 1'b0;
  logic             EN       = 1'b0;
  logic             CLR_ERR  = 1'b0;
  logic             EOC      = 1'b0;
  logic             EOS      = 1'b0;
  logic             SENSOR_CLK, ST, PIX_VALID, FRAME_DONE, ERR_COUNT, ERR_OVF;
  logic [PIX_W-1:0] PIX_INDEX, FRAME_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_en     = 0;

  typedef struct {
    int cyc;
    int val;
    bit errc;
    bit ovf;
  } exp_t;

  exp_t pix_q[$];
  exp_t frm_q[$];

  bit m_aligned = 1'b0;
  int m_cnt     = 0;
  bit m_errc    = 1'b0;
  bit m_ovf     = 1'b0;
  int m_last_fc = 0;

  sensor_frame_ctrl #(
    .DIV(DIV), .ST_PERIOD(ST_PERIOD), .ST_HIGH(ST_HIGH),
    .NPIX(NPIX), .PIX_W(PIX_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST), .EN(EN), .CLR_ERR(CLR_ERR),
    .EOC(EOC), .EOS(EOS), .SENSOR_CLK(SENSOR_CLK), .ST(ST),
    .PIX_VALID(PIX_VALID), .PIX_INDEX(PIX_INDEX), .FRAME_DONE(FRAME_DONE),
    .FRAME_COUNT(FRAME_COUNT), .ERR_COUNT(ERR_COUNT), .ERR_OVF(ERR_OVF)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  always @(posedge FPGA_CLK) cyc <= cyc + 1;

  // Number of consecutive enabled clock edges since reset or EN low.
  always @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) n_en <= 0;
    else if (EN)   n_en <= n_en + 1;
    else           n_en <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: what each detected edge should produce.
  task automatic model_edge(input bit e_oc, input bit e_os);
    exp_t e;
    if (!m_aligned) begin
      if (e_os) begin
        m_aligned = 1'b1;
        m_cnt     = 0;
      end
    end else begin
      if (e_oc) begin
        e.cyc = cyc + LAT; e.val = m_cnt; e.errc = 1'b0; e.ovf = 1'b0;
        pix_q.push_back(e);
        if (m_cnt == PIX_MAX) m_ovf = 1'b1;
        else                  m_cnt = m_cnt + 1;
      end
      if (e_os) begin
        if (m_cnt != NPIX) m_errc = 1'b1;
        e.cyc = cyc + LAT; e.val = m_cnt; e.errc = m_errc; e.ovf = m_ovf;
        frm_q.push_back(e);
        m_last_fc = m_cnt;
        m_cnt     = 0;
      end
    end
  endtask

  task automatic pulse(input bit e_oc, input bit e_os);
    @(negedge FPGA_CLK);
    EOC = e_oc;
    EOS = e_os;
    model_edge(e_oc, e_os);
    repeat (2) @(negedge FPGA_CLK);
    EOC = 1'b0;
    EOS = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge FPGA_CLK);
  endtask

  task automatic frame(input int n_eoc, input bit simul);
    for (int i = 0; i < n_eoc - (simul ? 1 : 0); i++) pulse(1'b1, 1'b0);
    pulse(simul, 1'b1);
  endtask

  task automatic clear_err();
    @(negedge FPGA_CLK);
    CLR_ERR = 1'b1;
    m_errc  = 1'b0;
    m_ovf   = 1'b0;
    @(negedge FPGA_CLK);
    CLR_ERR = 1'b0;
    check("err_count_clr", 32'(ERR_COUNT), 32'(m_errc));
    check("err_ovf_clr", 32'(ERR_OVF), 32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sensor_clk"}, 32'(SENSOR_CLK), 0);
    check({tag, "_st"}, 32'(ST), 0);
    check({tag, "_pix_valid"}, 32'(PIX_VALID), 0);
    check({tag, "_pix_index"}, 32'(PIX_INDEX), 0);
    check({tag, "_frame_done"}, 32'(FRAME_DONE), 0);
    check({tag, "_frame_count"}, 32'(FRAME_COUNT), 0);
    check({tag, "_err_count"}, 32'(ERR_COUNT), 0);
    check({tag, "_err_ovf"}, 32'(ERR_OVF), 0);
  endtask

  // SENSOR_CLK / ST reference from the enabled edge count.
  initial begin
    int k;
    forever begin
      @(negedge FPGA_CLK);
      k = n_en / DIV;
      check("sensor_clk", 32'(SENSOR_CLK), 32'(k % 2));
      check("st", 32'(ST), 32'((((k + 1) / 2) % ST_PERIOD) >= (ST_PERIOD - ST_HIGH)));
    end
  end

  // Scoreboard monitor: pops an expectation whenever a strobe appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge FPGA_CLK);
      if (PIX_VALID === 1'b1) begin
        if (pix_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pix_unexpected: PIX_VALID with index %0d, no pixel expected (cycle %0d)", PIX_INDEX, cyc);
        end else begin
          e = pix_q.pop_front();
          check("pix_index", 32'(PIX_INDEX), 32'(e.val));
          check("pix_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (FRAME_DONE === 1'b1) begin
        if (frm_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_unexpected: FRAME_DONE with count %0d, no frame expected (cycle %0d)", FRAME_COUNT, cyc);
        end else begin
          e = frm_q.pop_front();
          check("frame_count", 32'(FRAME_COUNT), 32'(e.val));
          check("frame_err_count", 32'(ERR_COUNT), 32'(e.errc));
          check("frame_err_ovf", 32'(ERR_OVF), 32'(e.ovf));
          check("frame_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d pixel and %0d frame events pending", pix_q.size(), frm_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit s;
    EN = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge FPGA_CLK);
    FPGA_RST = 1'b1;
    repeat (50) @(negedge FPGA_CLK);

    // EOCs before the first EOS are discarded; that EOS only aligns.
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);

    frame(4, 1'b0);
    frame(4, 1'b1);
    frame(2, 1'b0);
    clear_err();
    frame(9, 1'b0);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 9);
      s = (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame(n, s);
    end
    repeat (8) @(negedge FPGA_CLK);
    clear_err();

    // Disable: frame state dropped, latched count retained.
    EN = 1'b0;
    m_aligned = 1'b0;
    m_cnt = 0;
    repeat (6) @(negedge FPGA_CLK);
    check("fc_retained", 32'(FRAME_COUNT), 32'(m_last_fc));
    EN = 1'b1;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    frame(4, 1'b0);
    frame(3, 1'b0);

    // Asynchronous reset mid-frame, between clock edges.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge FPGA_CLK);
    @(posedge FPGA_CLK);
    #2;
    FPGA_RST = 1'b0;
    m_aligned = 1'b0;
    m_cnt = 0;
    m_errc = 1'b0;
    m_ovf = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge FPGA_CLK);
    FPGA_RST = 1'b1;
    pulse(1'b0, 1'b1);
    frame(4, 1'b0);
    frame(1, 1'b1);

    repeat (10) @(negedge FPGA_CLK);
    check("pix_q_drained", 32'(pix_q.size()), 0);
    check("frm_q_drained", 32'(frm_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
